regfile32: RTL

- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the shift/ALU stage. Read port 1 supplies the rs operand and read port 2 supplies the rt operand. Port 2 is the value sll32 shifts, by the instr[10:6] shift amount.
- Writeback from the ALU/memory mux returns here on the clock edge.
- Also provides a registered debug read port and write statistics for the board display.

---
 rtl/regfile32_if.sv | 43 ++++
 rtl/regfile32.sv | 82 ++++++++
 2 files changed

// File: rtl/regfile32_if.sv
// rtl/regfile32_if.sv - bus interface for the 32 x 32-bit register file
//
// Groups the write, read, debug and statistics signals of regfile32.
// Macro REGFILE_BYPASS_EN (see rtl/regfile32.sv) does not change this interface.
//
// Signals:
//   we        write enable from the control unit
//   wa, wd    write index / write data from the writeback mux
//   ra1, rd1  rs read index / combinational read data
//   ra2, rd2  rt read index / combinational read data (shifter A input)
//   dbg_addr  debug/display read index
//   dbg_data  registered debug read data (one-cycle latency)
//   wr_count  saturating count of committed writes since reset
//   last_wa   index of the most recent committed write
//
// Modports: master drives the requests, slave is the register file.
interface regfile32_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [WIDTH-1:0]  dbg_data;
  logic [CNT_W-1:0]  wr_count;
  logic [ADDR_W-1:0] last_wa;

  modport master (
    output we, wa, wd, ra1, ra2, dbg_addr,
    input  rd1, rd2, dbg_data, wr_count, last_wa
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, dbg_addr,
    output rd1, rd2, dbg_data, wr_count, last_wa
  );
endinterface

// File: rtl/regfile32.sv
// rtl/regfile32.sv - 32 x 32-bit general-purpose register file with debug port
//
// Register file for the single-cycle MIPS datapath. Register 0 is hard-wired
// to zero. Reads are combinational; writes commit on the rising clock edge.
// Also provides a registered debug read port and write statistics.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   bus        regfile32_if.slave: we/wa/wd, ra1/rd1, ra2/rd2,
//              dbg_addr/dbg_data, wr_count, last_wa
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   defined   - rd1/rd2 forward wd when the same-cycle write targets the
//               read index (write-first); suppressed while rst=1
//   undefined - read-old semantics, no bypass logic
module regfile32 #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic        clk,
  input logic        rst,
  regfile32_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  // Entry 0 exists only so every index is in range; it is never written
  // and every read path masks index 0 to zero.
  logic [WIDTH-1:0]  r_mem [NREG];
  logic [WIDTH-1:0]  r_dbg_data;
  logic [CNT_W-1:0]  r_wr_count;
  logic [ADDR_W-1:0] r_last_wa;

  logic              w_commit;
  logic              w_cnt_sat;
  logic [WIDTH-1:0]  w_rd1_stored;
  logic [WIDTH-1:0]  w_rd2_stored;
  logic [WIDTH-1:0]  w_dbg_stored;

  // A write with index 0 or during reset changes no state at all.
  assign w_commit  = bus.we && (bus.wa != '0) && !rst;
  assign w_cnt_sat = &r_wr_count;

  assign w_rd1_stored = (bus.ra1 == '0) ? '0 : r_mem[bus.ra1];
  assign w_rd2_stored = (bus.ra2 == '0) ? '0 : r_mem[bus.ra2];
  assign w_dbg_stored = (bus.dbg_addr == '0) ? '0 : r_mem[bus.dbg_addr];

`ifdef REGFILE_BYPASS_EN
  // Forwarding reuses w_commit, so it is off for wa=0 and while rst=1.
  assign bus.rd1 = (w_commit && (bus.ra1 == bus.wa)) ? bus.wd : w_rd1_stored;
  assign bus.rd2 = (w_commit && (bus.ra2 == bus.wa)) ? bus.wd : w_rd2_stored;
`else
  assign bus.rd1 = w_rd1_stored;
  assign bus.rd2 = w_rd2_stored;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
      r_dbg_data <= '0;
      r_wr_count <= '0;
      r_last_wa  <= '0;
    end else begin
      // Debug read samples pre-write contents (read-old) in all builds.
      r_dbg_data <= w_dbg_stored;
      if (w_commit) begin
        r_mem[bus.wa] <= bus.wd;
        r_last_wa     <= bus.wa;
        if (!w_cnt_sat) begin
          r_wr_count <= r_wr_count + CNT_W'(1);
        end
      end
    end
  end

  assign bus.dbg_data = r_dbg_data;
  assign bus.wr_count = r_wr_count;
  assign bus.last_wa  = r_last_wa;
endmodule
